flip_engine: RTL

FLIP_ENGINE -- requirements
Module: flip_engine

---
 rtl/othello_pkg.sv | 43 ++++
 rtl/flip_engine_if.sv | 24 ++
 rtl/flip_engine.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/othello_pkg.sv
// Shared definitions for the Othello flip engine: cell encodings, the board
// type, the eight scan-direction offsets and the controller state encoding.
package othello_pkg;

  localparam logic [1:0] BLACK = 2'd0;
  localparam logic [1:0] WHITE = 2'd1;
  localparam logic [1:0] EMPTY = 2'd2;

  // board[row][col], each cell 2 bits
  typedef logic [7:0][7:0][1:0] board_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SCAN,
    S_FLIP,
    S_NEXT,
    S_DONE
  } state_t;

  // Direction order N, NE, E, SE, S, SW, W, NW as signed 4-bit row/col steps
  localparam logic signed [3:0] DIR_DR [8] = '{4'shF, 4'shF, 4'sh0, 4'sh1,
                                               4'sh1, 4'sh1, 4'sh0, 4'shF};
  localparam logic signed [3:0] DIR_DC [8] = '{4'sh0, 4'sh1, 4'sh1, 4'sh1,
                                               4'sh0, 4'shF, 4'shF, 4'shF};

  // A board with every cell empty
  function automatic board_t empty_board();
    board_t b;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        b[r][c] = EMPTY;
      end
    end
    return b;
  endfunction

  // Widen a 3-bit board index into a signed 4-bit coordinate
  function automatic logic signed [3:0] to_coord(input logic [2:0] v);
    return $signed({1'b0, v});
  endfunction

endpackage

// File: rtl/flip_engine_if.sv
// Move request / result bundle between a requester and the flip engine.
interface flip_engine_if;
  import othello_pkg::*;

  logic       i_start;
  logic       i_color;
  logic [2:0] i_row;
  logic [2:0] i_col;
  board_t     i_current_board;
  board_t     o_updated_board;
  logic [4:0] o_flip;
  logic       o_done;

  modport master (
    output i_start, i_color, i_row, i_col, i_current_board,
    input  o_updated_board, o_flip, o_done
  );

  modport slave (
    input  i_start, i_color, i_row, i_col, i_current_board,
    output o_updated_board, o_flip, o_done
  );

endinterface

// File: rtl/flip_engine.sv
// Othello move engine: latches a board and a target cell, walks the eight
// directions one cell per cycle, flips bracketed opponent runs and reports
// the resulting board together with the number of discs flipped.
module flip_engine
  import othello_pkg::*;
(
  input logic          i_clk,
  input logic          i_rst,
  flip_engine_if.slave bus
);

  state_t            state_q, state_d;
  logic              color_q;
  logic [2:0]        row_q, col_q;
  board_t            board_w;
  board_t            final_board;
  board_t            out_board;
  logic [4:0]        flip_cnt;
  logic [4:0]        out_flip;
  logic [2:0]        dir_q, dir_nxt;
  logic [2:0]        run_q;
  logic signed [3:0] cur_r, cur_c;
  logic signed [3:0] tgt_r, tgt_c;
  logic signed [3:0] dr, dc;
  logic [1:0]        own_cell, opp_cell, scan_cell, tgt_cell;
  logic              off_board;

  assign own_cell  = {1'b0, color_q};
  assign opp_cell  = {1'b0, ~color_q};
  assign tgt_r     = to_coord(row_q);
  assign tgt_c     = to_coord(col_q);
  assign dr        = DIR_DR[dir_q];
  assign dc        = DIR_DC[dir_q];
  assign dir_nxt   = dir_q + 3'd1;
  assign tgt_cell  = board_w[row_q][col_q];
  assign scan_cell = board_w[cur_r[2:0]][cur_c[2:0]];
  // Coordinates only ever move one step past the edge, so -1 and 8 both set
  // bit 3; an on-board coordinate 0..7 never does. No wrap is possible.
  assign off_board = cur_r[3] | cur_c[3];

  assign bus.o_done          = (state_q == S_DONE);
  assign bus.o_updated_board = out_board;
  assign bus.o_flip          = out_flip;

  // Working board as it should look on entry to S_DONE: target claimed only if something flipped
  always_comb begin
    final_board = board_w;
    if (flip_cnt != 5'd0) begin
      final_board[row_q][col_q] = own_cell;
    end
  end

  // Controller state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: one scan or flip step per cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_start) state_d = S_CHECK;
      S_CHECK: state_d = (tgt_cell != EMPTY) ? S_DONE : S_SCAN;
      S_SCAN: begin
        if (off_board) begin
          state_d = S_NEXT;
        end else if (scan_cell == opp_cell) begin
          state_d = S_SCAN;
        end else if (scan_cell == own_cell && run_q != 3'd0) begin
          state_d = S_FLIP;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_FLIP:  if (run_q == 3'd1) state_d = S_NEXT;
      S_NEXT:  state_d = (dir_q == 3'd7) ? S_DONE : S_SCAN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: request latch, scan cursor, run length, flips and result registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      color_q   <= 1'b0;
      row_q     <= 3'd0;
      col_q     <= 3'd0;
      board_w   <= empty_board();
      flip_cnt  <= 5'd0;
      dir_q     <= 3'd0;
      run_q     <= 3'd0;
      cur_r     <= 4'sd0;
      cur_c     <= 4'sd0;
      out_board <= empty_board();
      out_flip  <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            color_q  <= bus.i_color;
            row_q    <= bus.i_row;
            col_q    <= bus.i_col;
            board_w  <= bus.i_current_board;
            flip_cnt <= 5'd0;
            out_flip <= 5'd0;
            dir_q    <= 3'd0;
            run_q    <= 3'd0;
          end
        end
        S_CHECK: begin
          cur_r <= tgt_r + dr;
          cur_c <= tgt_c + dc;
        end
        S_SCAN: begin
          if (!off_board && scan_cell == opp_cell) begin
            run_q <= run_q + 3'd1;
            cur_r <= cur_r + dr;
            cur_c <= cur_c + dc;
          end else if (!off_board && scan_cell == own_cell && run_q != 3'd0) begin
            cur_r <= cur_r - dr;
            cur_c <= cur_c - dc;
          end
        end
        S_FLIP: begin
          board_w[cur_r[2:0]][cur_c[2:0]] <= own_cell;
          flip_cnt <= flip_cnt + 5'd1;
          run_q    <= run_q - 3'd1;
          cur_r    <= cur_r - dr;
          cur_c    <= cur_c - dc;
        end
        S_NEXT: begin
          run_q <= 3'd0;
          if (dir_q != 3'd7) begin
            dir_q <= dir_nxt;
            cur_r <= tgt_r + DIR_DR[dir_nxt];
            cur_c <= tgt_c + DIR_DC[dir_nxt];
          end
        end
        default: begin
        end
      endcase
      if (state_d == S_DONE) begin
        board_w   <= final_board;
        out_board <= final_board;
        out_flip  <= flip_cnt;
      end
    end
  end

endmodule
